instr_fetch_stage: RTL and testbench

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

---
 rtl/instr_fetch_stage_pkg.sv | 12 +
 rtl/instr_fetch_stage_ifid_reg.sv | 58 +++++
 rtl/instr_fetch_stage.sv | 96 +++++++++
 tb/tb_instr_fetch_stage.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// Types and constants shared by the pipeline stages of the CPU.
package instr_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INS_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_stage_ifid_reg.sv
// IF/ID pipeline register. A flush inserts a bubble and takes priority over a load.
module ifid_reg
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned       PC_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [31:0]       NOP_INS  = NOP_INS_DEFAULT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic            flush,
  input  logic [31:0]     ins_in,
  input  logic [PC_W-1:0] pc_in,
  output logic [31:0]     ins,
  output logic [PC_W-1:0] pc,
  output logic            valid
);

  logic [31:0]     ins_q, ins_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  // Next-state selection; a flush keeps the latched PC.
  always_comb begin
    ins_d   = ins_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      ins_d   = NOP_INS;
      valid_d = 1'b0;
    end else if (load) begin
      ins_d   = ins_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Register update with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ins_q   <= NOP_INS;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      ins_q   <= ins_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign ins   = ins_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC register, WAIT/RUN/HALT control and the IF/ID register.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned       PC_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [31:0]       NOP_INS  = NOP_INS_DEFAULT
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_ins,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt,
  output logic [31:0]     ifid_ins,
  output logic [PC_W-1:0] ifid_pc,
  output logic            ifid_valid,
  output logic [31:0]     fetch_count,
  output logic            halted
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     count_q, count_d;
  logic            load_s, flush_s;

  // Control: in RUN, halt beats redirect beats stall beats advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    load_s  = 1'b0;
    flush_s = 1'b0;
    case (state_q)
      ST_WAIT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALT;
          flush_s = 1'b1;
        end else if (redirect) begin
          pc_d    = redirect_pc;
          flush_s = 1'b1;
        end else if (stall) begin
          pc_d    = pc_q;
        end else begin
          pc_d    = pc_q + PC_ONE;
          count_d = count_q + 32'd1;
          load_s  = 1'b1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: begin
        state_d = ST_WAIT;
        flush_s = 1'b1;
      end
    endcase
  end

  // State, PC and fetch counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_WAIT;
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  ifid_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC),
    .NOP_INS  (NOP_INS)
  ) u_ifid_reg (
    .clk    (clk),
    .rstn   (rstn),
    .load   (load_s),
    .flush  (flush_s),
    .ins_in (imem_ins),
    .pc_in  (pc_q),
    .ins    (ifid_ins),
    .pc     (ifid_pc),
    .valid  (ifid_valid)
  );

  assign imem_addr   = pc_q;
  assign fetch_count = count_q;
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage; a 5-bit instance covers PC wrap-around.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] imem_addr, imem_ins, redirect_pc;
  logic        stall, redirect, halt;
  logic [31:0] ifid_ins, ifid_pc, fetch_count;
  logic        ifid_valid, halted;

  logic [4:0]  imem_addr5, ifid_pc5;
  logic [31:0] imem_ins5, ifid_ins5, fetch_count5;
  logic        ifid_valid5, halted5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_ins  = imem_addr + 32'h100;
  assign imem_ins5 = {27'd0, imem_addr5} + 32'h200;

  instr_fetch_stage dut (
    .clk(clk), .rstn(rstn), .imem_addr(imem_addr), .imem_ins(imem_ins),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .ifid_ins(ifid_ins), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
    .fetch_count(fetch_count), .halted(halted)
  );

  instr_fetch_stage #(.PC_W(5), .RESET_PC(5'd31)) dut5 (
    .clk(clk), .rstn(rstn), .imem_addr(imem_addr5), .imem_ins(imem_ins5),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(5'd0), .halt(1'b0),
    .ifid_ins(ifid_ins5), .ifid_pc(ifid_pc5), .ifid_valid(ifid_valid5),
    .fetch_count(fetch_count5), .halted(halted5)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_addr"},   imem_addr,   32'h0);
    check_eq({tag, "_ins"},    ifid_ins,    32'h0);
    check_eq({tag, "_pc"},     ifid_pc,     32'h0);
    check_eq({tag, "_valid"},  {31'd0, ifid_valid}, 32'd0);
    check_eq({tag, "_count"},  fetch_count, 32'd0);
    check_eq({tag, "_halted"}, {31'd0, halted},     32'd0);
  endtask

  initial begin
    rstn = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 32'h0;
    #3;
    check_reset_values("rst");
    #9 rstn = 1'b1;

    // edge 1: WAIT
    tick();
    check_eq("wait_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("wait_addr",  imem_addr, 32'h0);

    // edges 2..5: fetch ROM[0..3]
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("run_pc",    ifid_pc,  i);
      check_eq("run_ins",   ifid_ins, 32'h100 + i);
      check_eq("run_valid", {31'd0, ifid_valid}, 32'd1);
      if (i == 0) begin
        check_eq("wrap_addr",  {27'd0, imem_addr5}, 32'd0);
        check_eq("wrap_pc",    {27'd0, ifid_pc5},   32'd31);
        check_eq("wrap_ins",   ifid_ins5, 32'h21F);
      end
    end
    check_eq("count4", fetch_count, 32'd4);
    check_eq("addr4",  imem_addr,   32'd4);

    tick();
    tick();
    check_eq("pre_stall_pc", ifid_pc,     32'd5);
    check_eq("pre_stall_ct", fetch_count, 32'd6);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_addr",  imem_addr,   32'd6);
      check_eq("stall_pc",    ifid_pc,     32'd5);
      check_eq("stall_count", fetch_count, 32'd6);
    end
    stall = 1'b0;
    tick();
    check_eq("unstall_pc",  ifid_pc,     32'd6);
    check_eq("unstall_ins", ifid_ins,    32'h106);
    check_eq("unstall_ct",  fetch_count, 32'd7);

    // redirect wins over stall
    redirect = 1'b1; redirect_pc = 32'h1C; stall = 1'b1;
    tick();
    check_eq("redir_addr",  imem_addr, 32'h1C);
    check_eq("redir_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("redir_ins",   ifid_ins,  32'h0);
    check_eq("redir_pc",    ifid_pc,   32'd6);
    check_eq("redir_count", fetch_count, 32'd7);
    redirect = 1'b0; stall = 1'b0; redirect_pc = 32'h77;
    tick();
    check_eq("post_redir_pc",  ifid_pc,  32'h1C);
    check_eq("post_redir_ins", ifid_ins, 32'h11C);
    check_eq("post_redir_ct",  fetch_count, 32'd8);

    // halt wins over redirect
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    check_eq("halt_halted", {31'd0, halted}, 32'd1);
    check_eq("halt_addr",   imem_addr, 32'h1D);
    check_eq("halt_valid",  {31'd0, ifid_valid}, 32'd0);
    check_eq("halt_ins",    ifid_ins,  32'h0);
    check_eq("halt_count",  fetch_count, 32'd8);
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      redirect = i[0];
      redirect_pc = 32'h50 + i;
      tick();
      check_eq("hold_addr",   imem_addr, 32'h1D);
      check_eq("hold_halted", {31'd0, halted}, 32'd1);
      check_eq("hold_count",  fetch_count, 32'd8);
    end
    check_eq("hold_valid", {31'd0, ifid_valid}, 32'd0);
    redirect = 1'b0;

    // asynchronous reset mid-cycle while halted
    #2 rstn = 1'b0;
    #1;
    check_reset_values("mid_rst");
    #2 rstn = 1'b1;
    tick();
    check_eq("rwait_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("rwait_addr",  imem_addr, 32'h0);
    tick();
    check_eq("resume_pc",    ifid_pc,  32'h0);
    check_eq("resume_ins",   ifid_ins, 32'h100);
    check_eq("resume_valid", {31'd0, ifid_valid}, 32'd1);
    check_eq("resume_addr",  imem_addr, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
